// File: rtl/vga_pkg.sv
// Shared raster timing defaults, scanout state encoding and the sync-level
// helper used by the frame-buffer scanout.
package vga_pkg;

  localparam int H_ACTIVE_DEF = 640;
  localparam int H_FP_DEF     = 16;
  localparam int H_SYNC_DEF   = 96;
  localparam int H_BP_DEF     = 48;
  localparam int V_ACTIVE_DEF = 480;
  localparam int V_FP_DEF     = 10;
  localparam int V_SYNC_DEF   = 2;
  localparam int V_BP_DEF     = 33;

  localparam int HT_DEF = H_ACTIVE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;
  localparam int VT_DEF = V_ACTIVE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  // Maps "sync asserted" onto the wire level for the chosen polarity.
  function automatic logic sync_level(input logic asserted, input logic active_low);
    return asserted ^ active_low;
  endfunction

endpackage

// File: rtl/vga_timing_gen.sv
// Horizontal/vertical raster counters and the stage-0 decode (active area,
// sync windows, vertical blank, first/last position of the frame).
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int H_FP     = H_FP_DEF,
  parameter int H_SYNC   = H_SYNC_DEF,
  parameter int H_BP     = H_BP_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF,
  parameter int V_FP     = V_FP_DEF,
  parameter int V_SYNC   = V_SYNC_DEF,
  parameter int V_BP     = V_BP_DEF
) (
  input  logic clk,
  input  logic resetn,
  input  logic run_i,
  output logic active_o,
  output logic hs_assert_o,
  output logic vs_assert_o,
  output logic vblank_o,
  output logic frame_first_o,
  output logic frame_last_o
);

  localparam int HT = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int VT = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW = $clog2(HT);
  localparam int VW = $clog2(VT);

  localparam logic [HW-1:0] H_LAST = HW'(HT - 1);
  localparam logic [HW-1:0] H_ACT  = HW'(H_ACTIVE);
  localparam logic [HW-1:0] H_SS   = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] H_SE   = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW-1:0] V_LAST = VW'(VT - 1);
  localparam logic [VW-1:0] V_ACT  = VW'(V_ACTIVE);
  localparam logic [VW-1:0] V_SS   = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] V_SE   = VW'(V_ACTIVE + V_FP + V_SYNC);

  logic [HW-1:0] h_q, h_d;
  logic [VW-1:0] v_q, v_d;

  // Counters sit at 0 while not running so a start always begins at pixel 0.
  always_comb begin
    h_d = '0;
    v_d = '0;
    if (run_i) begin
      h_d = h_q + HW'(1);
      v_d = v_q;
      if (h_q == H_LAST) begin
        h_d = '0;
        v_d = (v_q == V_LAST) ? '0 : v_q + VW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      h_q <= '0;
      v_q <= '0;
    end else begin
      h_q <= h_d;
      v_q <= v_d;
    end
  end

  assign active_o      = run_i && (h_q < H_ACT) && (v_q < V_ACT);
  assign hs_assert_o   = run_i && (h_q >= H_SS) && (h_q < H_SE);
  assign vs_assert_o   = run_i && (v_q >= V_SS) && (v_q < V_SE);
  assign vblank_o      = (v_q >= V_ACT);
  assign frame_first_o = (h_q == '0) && (v_q == '0);
  assign frame_last_o  = (h_q == H_LAST) && (v_q == V_LAST);

endmodule

// File: rtl/vga_scanout.sv
// Frame-buffer read master: raster FSM, linear read pointer, and the stage-1
// registers that line hsync/vsync/de up with the registered read data.
module vga_scanout
  import vga_pkg::*;
#(
  parameter int DATAW           = 24,
  parameter int addrLength      = 20,
  parameter int totalPixel      = 307200,
  parameter int H_ACTIVE        = H_ACTIVE_DEF,
  parameter int H_FP            = H_FP_DEF,
  parameter int H_SYNC          = H_SYNC_DEF,
  parameter int H_BP            = H_BP_DEF,
  parameter int V_ACTIVE        = V_ACTIVE_DEF,
  parameter int V_FP            = V_FP_DEF,
  parameter int V_SYNC          = V_SYNC_DEF,
  parameter int V_BP            = V_BP_DEF,
  parameter bit SYNC_ACTIVE_LOW = 1'b1
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  enable,
  input  logic [DATAW-1:0]      pixelIn,
  output logic                  readEn,
  output logic [addrLength-1:0] readPointer,
  output logic                  hsync,
  output logic                  vsync,
  output logic                  de,
  output logic [DATAW-1:0]      rgb,
  output logic                  vblank,
  output logic                  frameStart,
  output logic [1:0]            state_o
);

  if (totalPixel != H_ACTIVE * V_ACTIVE) begin : g_total_check
    $error("vga_scanout: totalPixel must equal H_ACTIVE*V_ACTIVE");
  end

  localparam logic [addrLength-1:0] PTR_LAST = addrLength'(totalPixel - 1);

  state_e state_q, state_d;
  logic   running, is_run;
  logic   active, hs_assert, vs_assert, vblank_raw, frame_first, frame_last;
  logic   [addrLength-1:0] ptr_q;
  logic   de_q, hsync_q, vsync_q, vblank_q, fs_q;

  vga_timing_gen #(
    .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
  ) u_timing (
    .clk           (clk),
    .resetn        (resetn),
    .run_i         (running),
    .active_o      (active),
    .hs_assert_o   (hs_assert),
    .vs_assert_o   (vs_assert),
    .vblank_o      (vblank_raw),
    .frame_first_o (frame_first),
    .frame_last_o  (frame_last)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  // DRAIN finishes the frame in progress; enable returning at any point
  // (including the last pixel) resumes RUN without a gap.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (enable) state_d = ST_RUN;
      ST_RUN:   if (!enable) state_d = ST_DRAIN;
      ST_DRAIN: begin
        if (enable)          state_d = ST_RUN;
        else if (frame_last) state_d = ST_IDLE;
      end
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    running = (state_q != ST_IDLE);
    is_run  = (state_q == ST_RUN);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ptr_q <= '0;
    end else if (active) begin
      ptr_q <= (ptr_q == PTR_LAST) ? '0 : ptr_q + addrLength'(1);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      de_q     <= 1'b0;
      hsync_q  <= sync_level(1'b0, SYNC_ACTIVE_LOW);
      vsync_q  <= sync_level(1'b0, SYNC_ACTIVE_LOW);
      vblank_q <= 1'b1;
      fs_q     <= 1'b0;
    end else begin
      de_q     <= active;
      hsync_q  <= sync_level(hs_assert, SYNC_ACTIVE_LOW);
      vsync_q  <= sync_level(vs_assert, SYNC_ACTIVE_LOW);
      vblank_q <= vblank_raw || !running;
      fs_q     <= frame_first && is_run;
    end
  end

  assign readEn      = active;
  assign readPointer = ptr_q;
  assign de          = de_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign vblank      = vblank_q;
  assign frameStart  = fs_q;
  assign rgb         = de_q ? pixelIn : '0;
  assign state_o     = state_q;

endmodule

// File: tb/tb_vga_scanout.sv
// Bench for vga_scanout on a reduced 16x10 raster (8x6 active, 48 pixels) with
// a registered-read frame buffer model holding mem[a] = a.
module tb_vga_scanout;
  import vga_pkg::*;

  localparam int DW = 24;
  localparam int AW = 20;
  localparam int HA = 8, HF = 2, HS = 3, HB = 3;
  localparam int VA = 6, VF = 1, VS = 2, VB = 1;
  localparam int TP = HA * VA;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  logic enable = 1'b0;

  logic [DW-1:0] pix_a = '0, pix_b = '0;
  logic          re_a, hs_a, vs_a, de_a, vb_a, fs_a;
  logic          re_b, hs_b, vs_b, de_b, vb_b, fs_b;
  logic [AW-1:0] ptr_a, ptr_b;
  logic [DW-1:0] rgb_a, rgb_b;
  logic [1:0]    st_a, st_b;

  always #5 clk = ~clk;

  vga_scanout #(
    .DATAW(DW), .addrLength(AW), .totalPixel(TP),
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .SYNC_ACTIVE_LOW(1'b1)
  ) dut_a (
    .clk(clk), .resetn(resetn), .enable(enable), .pixelIn(pix_a),
    .readEn(re_a), .readPointer(ptr_a), .hsync(hs_a), .vsync(vs_a),
    .de(de_a), .rgb(rgb_a), .vblank(vb_a), .frameStart(fs_a), .state_o(st_a)
  );

  vga_scanout #(
    .DATAW(DW), .addrLength(AW), .totalPixel(TP),
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .SYNC_ACTIVE_LOW(1'b0)
  ) dut_b (
    .clk(clk), .resetn(resetn), .enable(enable), .pixelIn(pix_b),
    .readEn(re_b), .readPointer(ptr_b), .hsync(hs_b), .vsync(vs_b),
    .de(de_b), .rgb(rgb_b), .vblank(vb_b), .frameStart(fs_b), .state_o(st_b)
  );

  // Registered-read frame buffers, contents equal to the address.
  always @(posedge clk) begin
    if (re_a) pix_a <= DW'(ptr_a);
    if (re_b) pix_b <= DW'(ptr_b);
  end

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Scoreboard: every read's address is predicted here and the pixel must
  // come back on rgb with the next de cycle.
  logic [DW-1:0] exp_q[$];
  int            sb_ptr = 0;

  always @(negedge clk) begin
    if (!resetn) begin
      exp_q.delete();
      sb_ptr = 0;
    end else begin
      if (re_a) begin
        check("sb_ptr", 32'(ptr_a), 32'(sb_ptr));
        exp_q.push_back(DW'(sb_ptr));
        sb_ptr = (sb_ptr == TP - 1) ? 0 : sb_ptr + 1;
      end
      if (de_a) begin
        check("sb_pending", 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() > 0) check("sb_rgb", 32'(rgb_a), 32'(exp_q.pop_front()));
      end else begin
        check("sb_blank_rgb", 32'(rgb_a), 32'd0);
      end
    end
  end

  typedef struct {
    int c;    // cycle index relative to the RUN entry edge
    int re;
    int ptr;
    int de;
    int rgb;
    int hs;   // sync asserted (logical, before polarity)
    int vs;
    int vb;
    int fs;
  } vec_t;

  vec_t vecs[17];

  int c, re_cnt, fs_cnt, last_ptr;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    if (re_a) begin
      re_cnt++;
      last_ptr = int'(ptr_a);
    end
    if (fs_a) fs_cnt++;
  endtask

  task automatic start_run();
    enable = 1'b1;
    step();
    c = 0;
    re_cnt = 0;
    fs_cnt = 0;
    last_ptr = -1;
    sample();
  endtask

  task automatic adv_to(input int target);
    while (c < target) begin
      step();
      c++;
      sample();
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_re"}, 32'(re_a), 32'd0);
    check({tag, "_de"}, 32'(de_a), 32'd0);
    check({tag, "_rgb"}, 32'(rgb_a), 32'd0);
    check({tag, "_hs_a"}, 32'(hs_a), 32'd1);
    check({tag, "_vs_a"}, 32'(vs_a), 32'd1);
    check({tag, "_hs_b"}, 32'(hs_b), 32'd0);
    check({tag, "_vs_b"}, 32'(vs_b), 32'd0);
    check({tag, "_vblank"}, 32'(vb_a), 32'd1);
    check({tag, "_fs"}, 32'(fs_a), 32'd0);
    check({tag, "_ptr"}, 32'(ptr_a), 32'd0);
    check({tag, "_state"}, 32'(st_a), 32'(ST_IDLE));
  endtask

  initial begin
    //            c    re ptr de rgb hs vs vb fs
    vecs[0]  = '{  0,  1,  0, 0,  0, 0, 0, 1, 0};
    vecs[1]  = '{  1,  1,  1, 1,  0, 0, 0, 0, 1};
    vecs[2]  = '{  2,  1,  2, 1,  1, 0, 0, 0, 0};
    vecs[3]  = '{  8,  0,  8, 1,  7, 0, 0, 0, 0};
    vecs[4]  = '{  9,  0,  8, 0,  0, 0, 0, 0, 0};
    vecs[5]  = '{ 11,  0,  8, 0,  0, 1, 0, 0, 0};
    vecs[6]  = '{ 14,  0,  8, 0,  0, 0, 0, 0, 0};
    vecs[7]  = '{ 17,  1,  9, 1,  8, 0, 0, 0, 0};
    vecs[8]  = '{ 96,  0,  0, 0,  0, 0, 0, 0, 0};
    vecs[9]  = '{ 97,  0,  0, 0,  0, 0, 0, 1, 0};
    vecs[10] = '{107,  0,  0, 0,  0, 1, 0, 1, 0};
    vecs[11] = '{113,  0,  0, 0,  0, 0, 1, 1, 0};
    vecs[12] = '{129,  0,  0, 0,  0, 0, 1, 1, 0};
    vecs[13] = '{145,  0,  0, 0,  0, 0, 0, 1, 0};
    vecs[14] = '{160,  1,  0, 0,  0, 0, 0, 1, 0};
    vecs[15] = '{161,  1,  1, 1,  0, 0, 0, 0, 1};
    vecs[16] = '{162,  1,  2, 1,  1, 0, 0, 0, 0};

    // Reset, then idle with enable low.
    repeat (3) step();
    check_idle("rst");
    resetn = 1'b1;
    repeat (10) step();
    check_idle("idle_hold");

    // Start, line/frame timing, pointer wrap and polarity.
    start_run();
    for (int i = 0; i < 17; i++) begin
      if (vecs[i].c >= 160 && c < 159) begin
        adv_to(159);
        check("frame_reads", 32'(re_cnt), 32'(TP));
        check("frame_last_ptr", 32'(last_ptr), 32'(TP - 1));
        check("frame_fs_count", 32'(fs_cnt), 32'd1);
      end
      adv_to(vecs[i].c);
      check($sformatf("v%0d_re", i), 32'(re_a), 32'(vecs[i].re));
      check($sformatf("v%0d_ptr", i), 32'(ptr_a), 32'(vecs[i].ptr));
      check($sformatf("v%0d_de", i), 32'(de_a), 32'(vecs[i].de));
      check($sformatf("v%0d_rgb", i), 32'(rgb_a), 32'(vecs[i].rgb));
      check($sformatf("v%0d_hs_a", i), 32'(hs_a), 32'(vecs[i].hs == 0));
      check($sformatf("v%0d_vs_a", i), 32'(vs_a), 32'(vecs[i].vs == 0));
      check($sformatf("v%0d_hs_b", i), 32'(hs_b), 32'(vecs[i].hs));
      check($sformatf("v%0d_vs_b", i), 32'(vs_b), 32'(vecs[i].vs));
      check($sformatf("v%0d_vblank", i), 32'(vb_a), 32'(vecs[i].vb));
      check($sformatf("v%0d_fs", i), 32'(fs_a), 32'(vecs[i].fs));
    end

    // Asynchronous reset in the middle of an active line.
    adv_to(165);
    check("pre_rst_re", 32'(re_a), 32'd1);
    check("pre_rst_de", 32'(de_a), 32'd1);
    resetn = 1'b0;
    enable = 1'b0;
    #1;
    check_idle("mid_rst");
    repeat (2) step();
    resetn = 1'b1;
    repeat (3) step();
    check_idle("post_rst");

    // Drain: enable drops on line 2, the frame still completes, then IDLE.
    start_run();
    adv_to(35);
    enable = 1'b0;
    adv_to(36);
    check("drain_state", 32'(st_a), 32'(ST_DRAIN));
    adv_to(139);
    check("drain_hsync", 32'(hs_a), 32'd0);
    adv_to(159);
    check("drain_state_end", 32'(st_a), 32'(ST_DRAIN));
    check("drain_reads", 32'(re_cnt), 32'(TP));
    check("drain_last_ptr", 32'(last_ptr), 32'(TP - 1));
    adv_to(160);
    check("drain_idle_state", 32'(st_a), 32'(ST_IDLE));
    check("drain_idle_re", 32'(re_a), 32'd0);
    check("drain_idle_ptr", 32'(ptr_a), 32'd0);
    adv_to(161);
    check("drain_idle_de", 32'(de_a), 32'd0);
    check("drain_idle_vblank", 32'(vb_a), 32'd1);
    check("drain_idle_fs", 32'(fs_a), 32'd0);
    adv_to(180);
    check("drain_idle_reads", 32'(re_cnt), 32'(TP));
    check("drain_idle_state2", 32'(st_a), 32'(ST_IDLE));

    // Enable re-asserted mid-drain: frame continues, next frame follows.
    start_run();
    adv_to(35);
    enable = 1'b0;
    adv_to(52);
    enable = 1'b1;
    adv_to(53);
    check("resume_state", 32'(st_a), 32'(ST_RUN));
    adv_to(159);
    check("resume_reads", 32'(re_cnt), 32'(TP));
    adv_to(160);
    check("resume_next_re", 32'(re_a), 32'd1);
    check("resume_next_ptr", 32'(ptr_a), 32'd0);
    adv_to(161);
    check("resume_next_fs", 32'(fs_a), 32'd1);

    // Enable returns exactly on the last pixel of a draining frame.
    enable = 1'b0;
    adv_to(319);
    check("edge_state", 32'(st_a), 32'(ST_DRAIN));
    enable = 1'b1;
    adv_to(320);
    check("edge_run_state", 32'(st_a), 32'(ST_RUN));
    check("edge_run_re", 32'(re_a), 32'd1);
    check("edge_run_ptr", 32'(ptr_a), 32'd0);
    adv_to(321);
    check("edge_run_fs", 32'(fs_a), 32'd1);
    check("edge_run_de", 32'(de_a), 32'd1);
    adv_to(330);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
